// File: rtl/mult_pkg.sv
// Shared definitions for the sequential 32x32 shift-add multiplier.
// Holds the operand width, the final iteration index and the FSM state encoding.
// Imported by the controller top.
package mult_pkg;

  localparam int         WIDTH     = 32;
  localparam logic [4:0] ITER_LAST = 5'd31;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ITER   = 3'd2,
    NEG_LO = 3'd3,
    NEG_HI = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/Adder32bits.sv
// 32-bit unsigned adder with carry-out, shared by every product-path addition.
// Latency: combinational.
// Backpressure: none.
module Adder32bits (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        cout
);

  // A single 33-bit sum; the top bit is the carry into the next word.
  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential MULT/MULTU: 32 shift-add steps, then an optional two-step 64-bit negate.
// Latency: Done_out arrives 35 cycles after Start_in (37 when the result is negated).
// Backpressure: none; Start_in is ignored while Busy_out is high or in DONE.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start_in,
  input  logic             Signed_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             Busy_out,
  output logic             Done_out,
  output logic [WIDTH-1:0] Hi_out,
  output logic [WIDTH-1:0] Lo_out
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] m;        // multiplicand (magnitude after LOAD)
  logic [WIDTH-1:0] p_hi;     // upper half of the running product
  logic [WIDTH-1:0] p_lo;     // multiplier bits shifting out / lower product half
  logic [4:0]       cnt;
  logic             sgn;      // captured Signed_in
  logic             neg;      // final product must be negated
  logic             carry;    // carry from the low-word negate into the high word
  logic [WIDTH-1:0] add_a, add_b, add_s;
  logic             add_c;

  Adder32bits u_add (
    .a    (add_a),
    .b    (add_b),
    .sum  (add_s),
    .cout (add_c)
  );

  // Steer the shared adder: accumulate in ITER, two's-complement the product in NEG_*.
  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state)
      ITER: begin
        add_a = p_hi;
        add_b = p_lo[0] ? m : '0;
      end
      NEG_LO: begin
        add_a = ~p_lo;
        add_b = 32'd1;
      end
      NEG_HI: begin
        add_a = ~p_hi;
        add_b = {31'd0, carry};
      end
      default: ;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start_in) state_nxt = LOAD;
      LOAD:    state_nxt = ITER;
      ITER:    if (cnt == ITER_LAST) state_nxt = neg ? NEG_LO : DONE;
      NEG_LO:  state_nxt = NEG_HI;
      NEG_HI:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath: capture raw operands, take magnitudes, shift-add, then negate if needed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      m     <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      cnt   <= '0;
      sgn   <= 1'b0;
      neg   <= 1'b0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start_in) begin
            m    <= A_in;
            p_lo <= B_in;
            sgn  <= Signed_in;
          end
        end
        LOAD: begin
          // -2^31 maps onto itself, which read as unsigned is the correct magnitude.
          if (sgn && m[31])    m    <= -m;
          if (sgn && p_lo[31]) p_lo <= -p_lo;
          p_hi  <= '0;
          cnt   <= '0;
          carry <= 1'b0;
          neg   <= sgn & (m[31] ^ p_lo[31]);
        end
        ITER: begin
          p_hi <= {add_c, add_s[WIDTH-1:1]};
          p_lo <= {add_s[0], p_lo[WIDTH-1:1]};
          cnt  <= cnt + 5'd1;
        end
        NEG_LO: begin
          p_lo  <= add_s;
          carry <= add_c;
        end
        NEG_HI: begin
          p_hi <= add_s;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs; the result registers only move when leaving DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      Busy_out <= 1'b0;
      Done_out <= 1'b0;
      Hi_out   <= '0;
      Lo_out   <= '0;
    end else begin
      Busy_out <= (state_nxt != IDLE);
      Done_out <= (state == DONE);
      if (state == DONE) begin
        Hi_out <= p_hi;
        Lo_out <= p_lo;
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: scoreboard of expected products and latencies.
// Directed corner cases, ignored Start pulses, mid-operation reset, back-to-back and random ops.
// Outputs are sampled 1 time unit after the rising edge.
module tb_mult_seq_ctrl;

  typedef struct {
    logic [63:0] res;
    int          start;
    int          lat;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        Start_in;
  logic        Signed_in;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic        Busy_out;
  logic        Done_out;
  logic [31:0] Hi_out;
  logic [31:0] Lo_out;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic [63:0] last_res = '0;
  exp_t        sb_q[$];
  exp_t        mon_e;

  mult_seq_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start_in  (Start_in),
    .Signed_in (Signed_in),
    .A_in      (A_in),
    .B_in      (B_in),
    .Busy_out  (Busy_out),
    .Done_out  (Done_out),
    .Hi_out    (Hi_out),
    .Lo_out    (Lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbv;
    if (sgn) begin
      sa  = {{32{a[31]}}, a};
      sbv = {{32{b[31]}}, b};
      return sa * sbv;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Monitor: every Done_out pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (Done_out) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("product", {Hi_out, Lo_out}, mon_e.res);
        check_eq("latency", 64'(cyc - mon_e.start), 64'(mon_e.lat));
        last_res = mon_e.res;
      end
    end
  end

  // Issue one operation from an IDLE negedge and wait for its Done_out.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit poke);
    exp_t        e;
    int          n, busy, d0;
    logic [63:0] held;
    bit          neg;
    neg     = sgn & (a[31] ^ b[31]);
    e.res   = model(sgn, a, b);
    e.lat   = neg ? 37 : 35;
    e.start = cyc;
    held    = last_res;
    d0      = done_cnt;
    sb_q.push_back(e);
    Signed_in = sgn;
    A_in      = a;
    B_in      = b;
    Start_in  = 1'b1;
    n    = 0;
    busy = 0;
    while (done_cnt == d0 && n < 80) begin
      @(negedge clk);
      n++;
      Start_in = 1'b0;
      if (poke && (n == 10 || n == 34)) begin
        Start_in  = 1'b1;
        A_in      = ~a;
        B_in      = b + 32'd1;
        Signed_in = ~sgn;
      end
      if (n == 10) check_eq("hold", {Hi_out, Lo_out}, held);
      if (Busy_out) busy++;
    end
    Start_in = 1'b0;
    if (done_cnt == d0) check_eq("timeout", 64'd0, 64'd1);
    else                check_eq("busy_cycles", 64'(busy), 64'(e.lat - 1));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int d0;
    reset     = 1'b0;
    Start_in  = 1'b0;
    Signed_in = 1'b0;
    A_in      = '0;
    B_in      = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(Busy_out), 64'd0);
    check_eq("rst_done", 64'(Done_out), 64'd0);
    check_eq("rst_hilo", {Hi_out, Lo_out}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op(1'b0, 32'd3, 32'd5, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(1'b1, 32'd0, 32'hFFFF_FFF9, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'd3, 1'b0);
    @(negedge clk);

    // Start pulses in ITER and DONE must not spawn a second operation.
    run_op(1'b0, 32'd123, 32'd456, 1'b1);
    d0 = done_cnt;
    repeat (45) @(negedge clk);
    check_eq("no_extra_done", 64'(done_cnt), 64'(d0));

    // Abort at ITER count 10 (start cycle + 12).
    Signed_in = 1'b0;
    A_in      = 32'd9;
    B_in      = 32'd9;
    Start_in  = 1'b1;
    @(negedge clk);
    Start_in = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", 64'(Busy_out), 64'd0);
    check_eq("abort_done", 64'(Done_out), 64'd0);
    check_eq("abort_hilo", {Hi_out, Lo_out}, 64'd0);
    reset    = 1'b1;
    last_res = '0;
    d0       = done_cnt;
    repeat (45) @(negedge clk);
    check_eq("abort_no_done", 64'(done_cnt), 64'(d0));
    run_op(1'b0, 32'd7, 32'd6, 1'b0);
    check_eq("after_abort_lo", 64'(Lo_out), 64'h2A);

    // Back-to-back: second Start in the IDLE cycle right after DONE.
    run_op(1'b1, 32'hFFFF_FFF0, 32'd100, 1'b0);
    run_op(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_op(1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
    end

    repeat (3) @(negedge clk);
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port Start_in, input, 1: request a multiply; sampled only in IDLE.
REQ-005 SHALL have port Signed_in, input, 1: 1 = MULT (two's complement), 0 = MULTU; sampled with Start_in.
REQ-006 SHALL have port A_in, input, 32: multiplicand; sampled with Start_in.
REQ-007 SHALL have port B_in, input, 32: multiplier; sampled with Start_in.
REQ-008 SHALL have port Busy_out, output, 1: high in every state except IDLE.
REQ-009 SHALL have port Done_out, output, 1: one-cycle pulse when a result is valid.
REQ-010 SHALL have port Hi_out, output, 32: upper 32 bits of the last 64-bit product.
REQ-011 SHALL have port Lo_out, output, 32: lower 32 bits of the last 64-bit product.

Function
REQ-012 SHALL implement states IDLE, LOAD, ITER, NEG_LO, NEG_HI and DONE.
REQ-013 IDLE SHALL move to LOAD when Start_in=1, capturing A_in, B_in and Signed_in; otherwise it stays in IDLE.
REQ-014 LOAD SHALL:
  - set M = |A| and P_lo = |B| (magnitudes only when Signed_in=1 and the sign bit is set);
  - set P_hi = 0, iteration counter = 0 and neg = Signed_in & (A[31]^B[31]);
  - then enter ITER.
REQ-015 Each ITER cycle SHALL form {C,S} = P_hi + (P_lo[0] ? M : 0) as a 33-bit sum, then load {P_hi,P_lo} <= {C,S,P_lo[31:1]}.
REQ-016 ITER SHALL execute exactly 32 cycles (counter 0..31); after the last cycle it goes to NEG_LO if neg=1, else DONE.
REQ-017 NEG_LO SHALL set P_lo = ~P_lo + 1 and register the carry-out; NEG_HI SHALL set P_hi = ~P_hi + carry; NEG_HI then goes to DONE.
REQ-018 DONE SHALL:
  - copy P_hi to Hi_out and P_lo to Lo_out;
  - assert Done_out for exactly that one cycle;
  - return to IDLE unconditionally.
REQ-019 Latency from the cycle Start_in is sampled in IDLE to the Done_out cycle SHALL be 35 cycles when neg=0 and 37 cycles when neg=1.
REQ-020 Hi_out and Lo_out SHALL be valid in the Done_out cycle, counted from the Start_in cycle as in REQ-019.
REQ-021 Hi_out and Lo_out SHALL hold the previous result throughout a new operation and change only in DONE.
REQ-022 Start_in SHALL be ignored in every state except IDLE, including DONE.
REQ-023 Operand -2^31 SHALL use magnitude 0x80000000 as unsigned 32-bit, giving exact results for all signed pairs.
REQ-024 A zero product with neg=1 SHALL still yield Hi=Lo=0.
REQ-025 All additions SHALL use one shared 32-bit adder with carry-out; no second wide adder is permitted for the product path.

Reset
REQ-026 When reset=0 at a rising edge, the block SHALL enter IDLE, clear all internal registers, and clear Hi_out, Lo_out, Busy_out and Done_out to 0.
REQ-027 Reset asserted mid-operation SHALL abort the operation without producing Done_out.
REQ-028 The first Start_in after reset release SHALL be accepted normally.

Structure
REQ-029 State encodings, WIDTH=32 and ITER_LAST=31 SHALL be defined in shared package mult_pkg.
REQ-030 The shared adder SHALL be one instance of the existing 32-bit adder-with-carry sub-module, Adder32bits.
REQ-031 Adder operand selection per state SHALL be:
  - ITER: P_hi and gated M;
  - NEG_LO: ~P_lo and 1;
  - NEG_HI: ~P_hi and carry.
REQ-032 All outputs SHALL be driven directly from registers.

Verification
REQ-033 MULTU 3 x 5 -> Hi=0x00000000, Lo=0x0000000F, Done_out 35 cycles after Start_in, Busy_out high for 34 cycles.
REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001; MULT -1 x -1 -> Hi=0x00000000, Lo=0x00000001 (35 cycles).
REQ-035 Signed corner cases:
  - MULT -3 x 5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1, Done_out at 37 cycles;
  - MULT 0x80000000 x 0x80000000 -> Hi=0x40000000, Lo=0x00000000;
  - MULT 0 x -7 -> Hi=Lo=0.
REQ-036 Start_in pulsed during ITER and during DONE with different operands -> ignored; exactly one Done_out occurs with the original result.
REQ-037 Reset at ITER count 10 -> next cycle Busy_out=0, Hi_out=Lo_out=0, no Done_out; a following MULTU 7 x 6 -> Lo=0x0000002A.
REQ-038 Back-to-back operations (Start_in high in the IDLE cycle after DONE) -> the second operation is accepted, and Hi_out/Lo_out hold the first result until the second DONE.
